// File: rtl/rr_req_pkg.sv
// Shared definitions for the round-robin request feeder: sizes, FSM states
// and the combinational round-robin pick used by the arbiter.
package rr_req_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

  // First set bit scanning upward from ptr with wrap; zero when nothing is pending.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] pending,
                                               input logic [IDX_W-1:0] ptr);
    logic [N_REQ-1:0] sel;
    logic             found;
    logic [IDX_W-1:0] idx;
    sel   = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N_REQ);
      if (!found && pending[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] rr_index(input logic [N_REQ-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_sync_edge.sv
// Multi-flop synchroniser for asynchronous request lines plus a rising-edge
// detector on the synchronised value.
module req_sync_edge #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] async_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] stage_q [SYNC_STAGES];
  logic [N-1:0] syncDly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
      syncDly_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
      syncDly_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = stage_q[SYNC_STAGES-1] & ~syncDly_q;

endmodule

// File: rtl/rr_onehot_requester.sv
// Round-robin feeder for the 8-to-3 one-hot encoder: latches request edges as
// sticky pending bits and offers one registered one-hot grant at a time.
module rr_onehot_requester import rr_req_pkg::*; #(
  parameter int N           = N_REQ,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] grant_onehot,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [N-1:0] pending,
  output logic         drop_pulse
);

  logic [N-1:0]     reqRise;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grantIdx;
  logic [N-1:0]     clearMask;
  rr_state_e        state_q, state_d;

  req_sync_edge #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (req_in),
    .rise_o  (reqRise)
  );

  assign grantIdx = rr_index(grant_q);

  // A fresh edge re-arms a bit even as its grant retires, so no request is lost.
  always_comb begin
    clearMask = '0;
    if (valid_q && grant_ready) clearMask = grant_q;
    pending_d = (pending_q & ~clearMask) | reqRise;
    drop_d    = |(reqRise & pending_q & ~clearMask);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (|pending_q) begin
          grant_d = rr_pick(pending_q, ptr_q);
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_d   = (grantIdx == IDX_W'(N-1)) ? '0 : grantIdx + 1'b1;
          grant_d = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      ptr_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
    end
  end

  assign grant_onehot = grant_q;
  assign grant_valid  = valid_q;
  assign pending      = pending_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_rr_onehot_requester.sv
// Bench for rr_onehot_requester: hand-derived vector tables for the directed
// scenarios, an async reset sequence, then random traffic against a model.
module tb_rr_onehot_requester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_in = '0;
  logic       grant_ready = 1'b0;
  logic [7:0] grant_onehot;
  logic       grant_valid;
  logic [7:0] pending;
  logic       drop_pulse;

  int checks = 0;
  int failures = 0;

  rr_onehot_requester #(.N(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .pending      (pending),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit         rstBefore;
    int         scen;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] g;
    logic       v;
    logic [7:0] p;
    logic       d;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pending set, offered index (-1 = none), pointer, and the
  // sampled request history feeding the two-stage synchroniser delay.
  bit [7:0] mPend;
  int       mOff;
  int       mPtr;
  bit       mDrop;
  bit [7:0] h1, h2, h3;

  task automatic addVec(input bit r, input int s, input logic [7:0] q, input logic rd,
                        input logic [7:0] g, input logic [7:0] p, input logic d);
    vec_t x;
    x.rstBefore = r; x.scen = s; x.req = q; x.rdy = rd;
    x.g = g; x.v = (g != 8'h00); x.p = p; x.d = d;
    vecs.push_back(x);
  endtask

  task automatic modelStep();
    bit [7:0] edges;
    bit [7:0] clr;
    bit       found;
    int       j;
    edges = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = req_in;
    clr = '0;
    if (mOff >= 0 && grant_ready) clr[mOff] = 1'b1;
    mDrop = |(edges & mPend & ~clr);
    if (mOff >= 0) begin
      if (grant_ready) begin
        mPtr = (mOff + 1) % 8;
        mOff = -1;
      end
    end else if (mPend != 0) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        j = (mPtr + k) % 8;
        if (!found && mPend[j]) begin
          mOff  = j;
          found = 1'b1;
        end
      end
    end
    mPend = (mPend & ~clr) | edges;
  endtask

  task automatic cmp(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] got %h want %h", name, idx, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [7:0] g, input logic v,
                             input logic [7:0] p, input logic d);
    cmp({tag, ".grant_onehot"}, idx, grant_onehot, g);
    cmp({tag, ".grant_valid"}, idx, {7'b0, grant_valid}, {7'b0, v});
    cmp({tag, ".pending"}, idx, pending, p);
    cmp({tag, ".drop_pulse"}, idx, {7'b0, drop_pulse}, {7'b0, d});
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic rd);
    req_in      = r;
    grant_ready = rd;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req_in = '0;
    grant_ready = 1'b0;
    mPend = '0; mOff = -1; mPtr = 0; mDrop = 1'b0;
    h1 = '0; h2 = '0; h3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 0, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] expG;

    // Scenario 1: single request on bit 3.
    addVec(1, 1, 8'h08, 1, 8'h00, 8'h00, 0);
    addVec(0, 1, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 1, 8'h00, 1, 8'h00, 8'h08, 0);
    addVec(0, 1, 8'h00, 1, 8'h08, 8'h08, 0);
    addVec(0, 1, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 1, 8'h00, 1, 8'h00, 8'h00, 0);
    // Scenario 2: round-robin over bits 0, 2, 7, then 0 and 7 after wrap.
    addVec(1, 2, 8'h85, 1, 8'h00, 8'h00, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h85, 0);
    addVec(0, 2, 8'h00, 1, 8'h01, 8'h85, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h84, 0);
    addVec(0, 2, 8'h00, 1, 8'h04, 8'h84, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h80, 0);
    addVec(0, 2, 8'h00, 1, 8'h80, 8'h80, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 2, 8'h81, 1, 8'h00, 8'h00, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h81, 0);
    addVec(0, 2, 8'h00, 1, 8'h01, 8'h81, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h80, 0);
    addVec(0, 2, 8'h00, 1, 8'h80, 8'h80, 0);
    addVec(0, 2, 8'h00, 1, 8'h00, 8'h00, 0);
    // Scenario 3: backpressure on grant 0x20 while bit 1 arrives.
    addVec(1, 3, 8'h20, 0, 8'h00, 8'h00, 0);
    addVec(0, 3, 8'h00, 0, 8'h00, 8'h00, 0);
    addVec(0, 3, 8'h00, 0, 8'h00, 8'h20, 0);
    addVec(0, 3, 8'h00, 0, 8'h20, 8'h20, 0);
    addVec(0, 3, 8'h00, 0, 8'h20, 8'h20, 0);
    addVec(0, 3, 8'h00, 0, 8'h20, 8'h20, 0);
    addVec(0, 3, 8'h00, 0, 8'h20, 8'h20, 0);
    addVec(0, 3, 8'h02, 0, 8'h20, 8'h20, 0);
    addVec(0, 3, 8'h00, 0, 8'h20, 8'h20, 0);
    addVec(0, 3, 8'h00, 0, 8'h20, 8'h22, 0);
    addVec(0, 3, 8'h00, 1, 8'h00, 8'h02, 0);
    addVec(0, 3, 8'h00, 1, 8'h02, 8'h02, 0);
    addVec(0, 3, 8'h00, 1, 8'h00, 8'h00, 0);
    // Scenario 4: second edge on pending bit 4 while grant 0x01 is held.
    addVec(1, 4, 8'h01, 0, 8'h00, 8'h00, 0);
    addVec(0, 4, 8'h00, 0, 8'h00, 8'h00, 0);
    addVec(0, 4, 8'h00, 0, 8'h00, 8'h01, 0);
    addVec(0, 4, 8'h10, 0, 8'h01, 8'h01, 0);
    addVec(0, 4, 8'h00, 0, 8'h01, 8'h01, 0);
    addVec(0, 4, 8'h10, 0, 8'h01, 8'h11, 0);
    addVec(0, 4, 8'h00, 0, 8'h01, 8'h11, 0);
    addVec(0, 4, 8'h00, 0, 8'h01, 8'h11, 1);
    addVec(0, 4, 8'h00, 0, 8'h01, 8'h11, 0);
    addVec(0, 4, 8'h00, 1, 8'h00, 8'h10, 0);
    addVec(0, 4, 8'h00, 1, 8'h10, 8'h10, 0);
    addVec(0, 4, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 4, 8'h00, 1, 8'h00, 8'h00, 0);
    // Scenario 5: bit 6 edge lands in the cycle its grant is accepted.
    addVec(1, 5, 8'h40, 0, 8'h00, 8'h00, 0);
    addVec(0, 5, 8'h00, 0, 8'h00, 8'h00, 0);
    addVec(0, 5, 8'h00, 0, 8'h00, 8'h40, 0);
    addVec(0, 5, 8'h00, 0, 8'h40, 8'h40, 0);
    addVec(0, 5, 8'h00, 0, 8'h40, 8'h40, 0);
    addVec(0, 5, 8'h40, 0, 8'h40, 8'h40, 0);
    addVec(0, 5, 8'h00, 0, 8'h40, 8'h40, 0);
    addVec(0, 5, 8'h00, 1, 8'h00, 8'h40, 0);
    addVec(0, 5, 8'h00, 1, 8'h40, 8'h40, 0);
    addVec(0, 5, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 5, 8'h00, 1, 8'h00, 8'h00, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rstBefore) doReset();
      applyStimulus(vecs[i].req, vecs[i].rdy);
      checkOutput($sformatf("scen%0d", vecs[i].scen), i, vecs[i].g, vecs[i].v, vecs[i].p, vecs[i].d);
    end

    // Asynchronous reset while a grant is offered with 0xF0 pending.
    doReset();
    applyStimulus(8'hF0, 1'b0);
    repeat (3) applyStimulus(8'h00, 1'b0);
    checkOutput("midrst_pre", 0, 8'h10, 1'b1, 8'hF0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("midrst_async", 0, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h00, 1'b1);
      checkOutput("midrst_after", i, 8'h00, 1'b0, 8'h00, 1'b0);
    end

    // Random traffic against the reference model.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(8'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0));
      expG = '0;
      if (mOff >= 0) expG[mOff] = 1'b1;
      checkOutput("rand", i, expG, (mOff >= 0), mPend, mDrop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_onehot_requester.md
Name: rr_onehot_requester

Overview:
- Upstream feeder for the team's 8-to-3 one-hot encoder.
- Collects eight asynchronous request lines and synchronises them, then latches each rising edge as a sticky pending bit.
- Issues one request at a time, selected round-robin, as a registered one-hot vector plus enable, so the encoder's input is always exactly one-hot or all-zero.
- A ready/valid handshake with the consumer retires each grant.

Parameters:
- N, 8: number of request lines; the encoder stage requires 8.
- SYNC_STAGES, 2: flip-flop depth of each request synchroniser, minimum 2.
- IDX_W, $clog2(N): width of the round-robin pointer; derived, not overridable.

Ports:
- clk  in  1: the block's single clock.
- rst_n  in  1: reset, asynchronous assert, active-low.
- req_in  in  N: asynchronous request lines; a rising edge raises a request.
- grant_onehot  out  N: registered grant vector, drives encoder d; one-hot or zero.
- grant_valid  out  1: registered, drives encoder enable; high while a grant is offered.
- grant_ready  in  1: consumer accepts the current grant in this cycle.
- pending  out  N: registered sticky pending requests (status).
- drop_pulse  out  1: one-cycle pulse when a rising edge hits a bit that is already pending.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - rst_n low forces, immediately: sync flops 0, edge-history 0, pending 0, ptr 0, state IDLE, grant_onehot 0, grant_valid 0, drop_pulse 0.
- Synchroniser and edge detect:
  - Each bit passes through SYNC_STAGES flops; the final stage is s[i].
  - Edge e[i] = s[i] & ~s_d[i], where s_d is s delayed one cycle.
  - A request held high through reset release therefore produces one edge after reset and is captured.
- Pending update, per cycle, per bit i:
  - Bit i is cleared if it is the granted bit and the grant is accepted this cycle (grant_valid & grant_ready).
  - Bit i is set if e[i]. Set wins over clear in the same cycle, so the request is re-queued and not lost.
  - drop_pulse=1 the next cycle if e[i] occurs while pending[i]=1 and bit i is not being cleared this cycle.
- FSM, states IDLE and GRANT:
  - IDLE, pending==0: stay in IDLE; outputs 0.
  - IDLE, pending!=0: select the first set bit scanning upward from index ptr, wrapping from N-1 to 0. Next cycle: grant_onehot = that bit, grant_valid=1, state GRANT.
  - GRANT, grant_ready=0: hold grant_onehot and grant_valid stable. New edges on other bits only set pending.
  - GRANT, grant_ready=1: clear that pending bit and set ptr = (granted index + 1) mod N. Next cycle: grant_onehot=0, grant_valid=0, state IDLE.
  - This gives a minimum of 2 cycles per grant. There is one mandatory idle bubble between grants, so the encoder input passes through zero between codes.
  - grant_ready while in IDLE is ignored.
- Latency with SYNC_STAGES=2 and the block idle:
  - req_in is first sampled high at edge k.
  - pending bit visible after edge k+2.
  - grant_valid high after edge k+3.
  - Each extra sync stage adds 1 cycle.
- Invariants:
  - $countones(grant_onehot) is 1 when grant_valid=1 and 0 otherwise.
  - grant_onehot is always a subset of the pending bits of the cycle in which it was selected.
- Pointer arithmetic: ptr is IDX_W bits with modulo-N wrap; granting bit N-1 sets ptr to 0.
- Reset mid-grant: the grant is abandoned and all pending requests are lost. No drop_pulse is generated.

Decomposition:
- Shared package rr_req_pkg:
  - N_REQ=8 and IDX_W=3.
  - FSM state typedef (IDLE, GRANT).
  - A function rr_pick(pending, ptr) returning the one-hot selection. It returns zero when pending==0.
- One natural sub-module: req_sync_edge. It holds the N-bit synchroniser plus rising-edge detector, is parameterised by N and SYNC_STAGES, and has clk/rst_n inputs.
- Arbitration, FSM and pending logic stay in rr_onehot_requester.

Test Plan:
- Reset and single request:
  - Stimulus: hold rst_n=0 with req_in=8'h00; release; pulse req_in[3] high for 1 cycle at edge k, grant_ready=1.
  - Required: grant_valid=1 and grant_onehot=8'h08 after edge k+3, for 1 cycle; then 8'h00; pending returns to 0.
- Round-robin order:
  - Stimulus: raise req_in bits 0, 2 and 7 in the same cycle; grant_ready=1.
  - Required: grants 8'h01, 8'h04, 8'h80, each separated by one zero cycle.
  - Follow-up: raise bits 0 and 7 again. Required: 8'h01 then 8'h80, since ptr wrapped to 0.
- Backpressure hold:
  - Stimulus: grant 8'h20 offered with grant_ready=0 for 5 cycles, then a bit 1 edge arrives.
  - Required: grant_onehot stays 8'h20 and pending shows 8'h22.
  - After grant_ready=1: 8'h00 for one cycle, then 8'h02.
- Drop detection:
  - Stimulus: two rising edges on bit 4 while grant_ready=0 holds another grant.
  - Required: drop_pulse=1 for exactly 1 cycle; pending[4] still 1; bit 4 granted only once.
- Simultaneous set and clear:
  - Stimulus: a new synchronised edge on bit 6 in the same cycle that grant 8'h40 is accepted.
  - Required: pending[6] stays 1; 8'h40 is granted again after one idle cycle; no drop_pulse.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while grant_valid=1 and pending=8'hF0.
  - Required: all outputs 0 immediately; after release, with req_in=0, no grants.
